// File: rtl/pll_lock_reset_gen_pkg.sv
// Shared state encoding and sizing helper for the PLL lock-qualified reset generator.
package pll_lock_reset_gen_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_STABILIZE = 2'b01,
        ST_RELEASE   = 2'b10,
        ST_RUN       = 2'b11
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_reset_gen_if.sv
// Lock input, status clear and staged reset/status outputs of pll_lock_reset_gen.
interface pll_lock_reset_gen_if #(
    parameter int unsigned NUM_RST_OUT = 3,
    parameter int unsigned LOSS_CNT_W  = 8
);
    logic                   PLL_LOCK;
    logic                   CLR_STATUS;
    logic [NUM_RST_OUT-1:0] FABRIC_RESET_N;
    logic                   READY;
    logic                   LOCK_LOST_STICKY;
    logic [LOSS_CNT_W-1:0]  LOCK_LOSS_COUNT;
    logic [1:0]             STATE;

    modport master (
        output PLL_LOCK, CLR_STATUS,
        input  FABRIC_RESET_N, READY, LOCK_LOST_STICKY, LOCK_LOSS_COUNT, STATE
    );

    modport slave (
        input  PLL_LOCK, CLR_STATUS,
        output FABRIC_RESET_N, READY, LOCK_LOST_STICKY, LOCK_LOSS_COUNT, STATE
    );
endinterface

// File: rtl/pll_lock_reset_gen_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit, cleared by the async reset.
module pll_lock_reset_gen_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/pll_lock_reset_gen.sv
// Holds fabric domains in reset until PLL lock is stable, releases them in order,
// and drops all of them on any lock loss while counting loss events.
module pll_lock_reset_gen
    import pll_lock_reset_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_STAGE_GAP      = 16,
    parameter int unsigned NUM_RST_OUT        = 3,
    parameter int unsigned LOSS_CNT_W         = 8
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    pll_lock_reset_gen_if.slave bus
);
    localparam int unsigned STAB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned GAP_W  = cnt_width(RST_STAGE_GAP);
    localparam int unsigned IDX_W  = cnt_width(NUM_RST_OUT);

    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(RST_STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_RST_OUT - 1);
    localparam logic [LOSS_CNT_W-1:0] CNT_MAX   = '1;

    logic lock_sync;

    pll_lock_reset_gen_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk   (SYSCLK),
        .rst_n (NSYSRESET),
        .d     (bus.PLL_LOCK),
        .q     (lock_sync)
    );

    state_e                 state_q, state_d;
    logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_RST_OUT-1:0] fabric_rst_n_q, fabric_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   sticky_q, sticky_d;
    logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
    logic                   lock_lost;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q        <= ST_WAIT_LOCK;
            stab_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            idx_q          <= '0;
            fabric_rst_n_q <= '0;
            ready_q        <= 1'b0;
            sticky_q       <= 1'b0;
            loss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            stab_cnt_q     <= stab_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            idx_q          <= idx_d;
            fabric_rst_n_q <= fabric_rst_n_d;
            ready_q        <= ready_d;
            sticky_q       <= sticky_d;
            loss_cnt_q     <= loss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d    = ST_STABILIZE;
                    stab_cnt_d = '0;
                end
            end
            ST_STABILIZE: begin
                if (!lock_sync) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d   = ST_RELEASE;
                    gap_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // gap_cnt==0 marks a release edge; reloading with GAP-1 spaces releases GAP apart
                if (!lock_sync) begin
                    state_d = ST_WAIT_LOCK;
                end else if (gap_cnt_q == '0) begin
                    gap_cnt_d = GAP_LAST;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_sync) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        fabric_rst_n_d = fabric_rst_n_q;
        ready_d        = ready_q;
        sticky_d       = sticky_q;
        loss_cnt_d     = loss_cnt_q;
        lock_lost      = 1'b0;
        case (state_q)
            ST_RELEASE: begin
                if (!lock_sync) begin
                    lock_lost = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    fabric_rst_n_d = fabric_rst_n_q | (NUM_RST_OUT'(1) << idx_q);
                    ready_d        = (idx_q == IDX_LAST);
                end
            end
            ST_RUN: begin
                if (!lock_sync) lock_lost = 1'b1;
            end
            default: begin
                fabric_rst_n_d = '0;
                ready_d        = 1'b0;
            end
        endcase
        if (lock_lost) begin
            fabric_rst_n_d = '0;
            ready_d        = 1'b0;
        end
        // Clear first so a coincident loss is still recorded as the first event
        if (bus.CLR_STATUS) begin
            sticky_d   = 1'b0;
            loss_cnt_d = '0;
        end
        if (lock_lost) begin
            sticky_d = 1'b1;
            if (loss_cnt_d != CNT_MAX) loss_cnt_d = loss_cnt_d + 1'b1;
        end
    end

    assign bus.FABRIC_RESET_N   = fabric_rst_n_q;
    assign bus.READY            = ready_q;
    assign bus.LOCK_LOST_STICKY = sticky_q;
    assign bus.LOCK_LOSS_COUNT  = loss_cnt_q;
    assign bus.STATE            = state_q;
endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Bench for pll_lock_reset_gen: reference model tracks the length of the current lock streak
// and derives every output from it; scenario tasks add fixed-edge timing checks.
module tb_pll_lock_reset_gen;
    localparam int L  = 8;
    localparam int G  = 4;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int VW = N + W + 4;

    logic SYSCLK    = 1'b0;
    logic NSYSRESET = 1'b0;
    int   n_vec     = 0;
    int   n_err     = 0;

    pll_lock_reset_gen_if #(.NUM_RST_OUT(N), .LOSS_CNT_W(W)) bus ();

    pll_lock_reset_gen #(
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .RST_STAGE_GAP      (G),
        .NUM_RST_OUT        (N),
        .LOSS_CNT_W         (W)
    ) dut (
        .SYSCLK    (SYSCLK),
        .NSYSRESET (NSYSRESET),
        .bus       (bus)
    );

    always #50 SYSCLK = ~SYSCLK;

    // m_s = number of consecutive edges that sampled lock_sync=1
    int m_s;
    bit m_p1, m_p2, m_ls, m_sticky;
    int m_count;

    always @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            m_s = 0; m_p1 = 0; m_p2 = 0; m_sticky = 0; m_count = 0;
        end else begin
            m_ls = m_p2;
            m_p2 = m_p1;
            m_p1 = bus.PLL_LOCK;
            if (bus.CLR_STATUS) begin
                m_sticky = 0;
                m_count  = 0;
            end
            if (m_ls) begin
                if (m_s < 100000) m_s++;
            end else begin
                if (m_s >= L + 1) begin
                    m_sticky = 1;
                    if (m_count < (1 << W) - 1) m_count++;
                end
                m_s = 0;
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] fab;
        logic         rdy;
        logic [1:0]   st;
        fab = '0;
        for (int j = 0; j < N; j++) fab[j] = (m_s >= L + 2 + j * G);
        rdy = fab[N-1];
        if (m_s == 0)      st = 2'b00;
        else if (m_s <= L) st = 2'b01;
        else if (!rdy)     st = 2'b10;
        else               st = 2'b11;
        return {fab, rdy, m_sticky, W'(m_count), st};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.FABRIC_RESET_N, bus.READY, bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT, bus.STATE};
    endfunction

    task automatic test_reset();
        NSYSRESET = 1'b0;
        bus.PLL_LOCK = 1'b0;
        bus.CLR_STATUS = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge SYSCLK);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_model cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (act_vec() !== '0) begin
            n_err++;
            $display("FAIL reset_zero got=%h want=0", act_vec());
        end
        @(posedge SYSCLK); #1 NSYSRESET = 1'b1;
    endtask

    task automatic test_lock_timing();
        logic [2:0] ek;
        logic [1:0] st;
        @(posedge SYSCLK); #1 bus.PLL_LOCK = 1'b1;
        for (int e = 0; e < 25; e++) begin
            @(posedge SYSCLK);
            @(negedge SYSCLK);
            ek = {e >= 19, e >= 15, e >= 11};
            st = (e < 2) ? 2'b00 : (e < 10) ? 2'b01 : (e < 19) ? 2'b10 : 2'b11;
            n_vec++;
            if ({bus.FABRIC_RESET_N, bus.READY, bus.STATE} !== {ek, e >= 19, st}) begin
                n_err++;
                $display("FAIL lock_timing E%0d got=%b/%b/%b want=%b/%b/%b", e,
                         bus.FABRIC_RESET_N, bus.READY, bus.STATE, ek, e >= 19, st);
            end
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL lock_model E%0d got=%h want=%h", e, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stab_glitch();
        @(posedge SYSCLK); #1 NSYSRESET = 1'b0; bus.PLL_LOCK = 1'b0;
        repeat (3) @(posedge SYSCLK);
        #1 NSYSRESET = 1'b1;
        @(posedge SYSCLK); #1 bus.PLL_LOCK = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(posedge SYSCLK);
            if (e == 5) #1 bus.PLL_LOCK = 1'b0;
            if (e == 8) #1 bus.PLL_LOCK = 1'b1;
            @(negedge SYSCLK);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL glitch_model E%0d got=%h want=%h", e, act_vec(), exp_vec());
            end
            if (e == 9 || e == 19 || e == 20) begin
                n_vec++;
                if ({bus.FABRIC_RESET_N, bus.STATE} !== {(e == 20) ? 3'b001 : 3'b000, (e == 9) ? 2'b00 : 2'b10}) begin
                    n_err++;
                    $display("FAIL glitch_requal E%0d got=%b/%b", e, bus.FABRIC_RESET_N, bus.STATE);
                end
            end
        end
        n_vec++;
        if ({bus.READY, bus.LOCK_LOSS_COUNT} !== {1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL glitch_end got=%b/%0d want=1/0", bus.READY, bus.LOCK_LOSS_COUNT);
        end
    endtask

    task automatic test_run_loss();
        @(posedge SYSCLK); #1 bus.PLL_LOCK = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge SYSCLK);
            if (k == 5) #1 bus.PLL_LOCK = 1'b1;
            @(negedge SYSCLK);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL loss_model k=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
            if (k == 2 || k == 3) begin
                n_vec++;
                if (act_vec() !== ((k == 2) ? {3'b111, 1'b1, 1'b0, 8'd0, 2'b11} : {3'b000, 1'b0, 1'b1, 8'd1, 2'b00})) begin
                    n_err++;
                    $display("FAIL loss_drop k=%0d got=%h", k, act_vec());
                end
            end
            if (k == 16 || k == 17 || k == 25) begin
                n_vec++;
                if (bus.FABRIC_RESET_N !== ((k == 16) ? 3'b000 : (k == 17) ? 3'b001 : 3'b111)) begin
                    n_err++;
                    $display("FAIL loss_rerelease k=%0d got=%b", k, bus.FABRIC_RESET_N);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int hi, lo;
        for (int i = 0; i < 260; i++) begin
            hi = $urandom_range(14, 10);
            lo = $urandom_range(5, 3);
            for (int k = 0; k < hi + lo; k++) begin
                bus.PLL_LOCK = (k < hi);
                @(negedge SYSCLK);
                n_vec++;
                if (act_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL sat_model i=%0d k=%0d got=%h want=%h", i, k, act_vec(), exp_vec());
                end
            end
        end
        n_vec++;
        if ({bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT} !== {1'b1, 8'd255}) begin
            n_err++;
            $display("FAIL sat_count got=%b/%0d want=1/255", bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT);
        end
        // Coincident clear and loss: PLL low sampled at P1, loss edge is P3
        bus.PLL_LOCK = 1'b1;
        repeat (14) @(negedge SYSCLK);
        bus.PLL_LOCK = 1'b0;
        repeat (2) @(negedge SYSCLK);
        bus.CLR_STATUS = 1'b1;
        @(negedge SYSCLK);
        bus.CLR_STATUS = 1'b0;
        n_vec++;
        if ({bus.FABRIC_RESET_N, bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT} !== {3'b000, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL clr_coincident got=%b/%b/%0d want=000/1/1",
                     bus.FABRIC_RESET_N, bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT);
        end
        n_vec++;
        if (act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL clr_coincident_model got=%h want=%h", act_vec(), exp_vec());
        end
        repeat (3) @(negedge SYSCLK);
        bus.CLR_STATUS = 1'b1;
        @(negedge SYSCLK);
        bus.CLR_STATUS = 1'b0;
        n_vec++;
        if ({bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT} !== {1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL clr_pulse got=%b/%0d want=0/0", bus.LOCK_LOST_STICKY, bus.LOCK_LOSS_COUNT);
        end
    endtask

    task automatic test_async_reset();
        bus.PLL_LOCK = 1'b0;
        repeat (4) @(negedge SYSCLK);
        bus.PLL_LOCK = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(negedge SYSCLK);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_model E%0d got=%h want=%h", e, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (bus.FABRIC_RESET_N !== 3'b001) begin
            n_err++;
            $display("FAIL arst_pre got=%b want=001", bus.FABRIC_RESET_N);
        end
        #10 NSYSRESET = 1'b0;
        #1;
        n_vec++;
        if (act_vec() !== '0) begin
            n_err++;
            $display("FAIL arst_async got=%h want=0", act_vec());
        end
        repeat (3) @(negedge SYSCLK);
        @(posedge SYSCLK); #1 NSYSRESET = 1'b1;
        for (int e = 0; e < 25; e++) begin
            @(negedge SYSCLK);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL arst_restart c=%0d got=%h want=%h", e, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if ({bus.READY, bus.STATE} !== 3'b111) begin
            n_err++;
            $display("FAIL arst_ready got=%b/%b want=1/11", bus.READY, bus.STATE);
        end
    endtask

    task automatic test_random();
        int  run;
        logic v;
        run = 0;
        v   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (run == 0) begin
                v   = ~v;
                run = v ? $urandom_range(30, 1) : $urandom_range(4, 1);
            end
            run--;
            bus.PLL_LOCK   = v;
            bus.CLR_STATUS = ($urandom_range(15, 0) == 0);
            @(negedge SYSCLK);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_model i=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        bus.CLR_STATUS = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog time=%0t limit=5ms", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_timing();
        test_stab_glitch();
        test_run_loss();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
